// File: rtl/multicycle_control.sv
// multicycle_control: multicycle LEGv8 main control FSM with memory handshake, sticky fault and retire counter
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    RST = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4, MEM_WB = 4'd5,
    MEM_WRITE = 4'd6, EXEC_R = 4'd7, R_WB = 4'd8, CBZ_EX = 4'd9, B_EX = 4'd10, FAULT = 4'd11
  } state_t;
  localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] LAST = WW'(MAX_WAIT > 0 ? MAX_WAIT - 1 : 0);
  state_t st, nxt;
  logic [WW-1:0] wcnt;
  logic [13:0] ctrl;
  logic is_ldur, is_stur, is_r, is_cbz, is_b, tmo, retire, pcw;
  assign is_ldur = Op == 11'b11111000010;
  assign is_stur = Op == 11'b11111000000;
  assign is_r = Op == 11'b10001011000 || Op == 11'b11001011000 || Op == 11'b10001010000 || Op == 11'b10101010000;
  assign is_cbz = Op[10:3] == 8'b10110100;
  assign is_b = Op[10:5] == 6'b000101;
  assign tmo = (MAX_WAIT != 0) && !mem_ready && wcnt == LAST;
  assign retire = st inside {MEM_WB, R_WB, CBZ_EX, B_EX} || (st == MEM_WRITE && mem_ready);
  // Control word for a state: {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  function automatic logic [13:0] dec(state_t s);
    case (s)
      FETCH:     return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      DECODE:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      MEM_ADDR:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      MEM_READ:  return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      MEM_WB:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      MEM_WRITE: return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      EXEC_R:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      R_WB:      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      CBZ_EX:    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      B_EX:      return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01};
      default:   return '0;
    endcase
  endfunction
  // Next-state selection, including opcode dispatch and memory-wait timeout
  always_comb begin
    nxt = st;
    case (st)
      RST:       nxt = FETCH;
      FETCH:     nxt = mem_ready ? DECODE : tmo ? FAULT : FETCH;
      DECODE:    nxt = (is_ldur || is_stur) ? MEM_ADDR : is_r ? EXEC_R : is_cbz ? CBZ_EX : is_b ? B_EX : FAULT;
      MEM_ADDR:  nxt = is_ldur ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt = mem_ready ? MEM_WB : tmo ? FAULT : MEM_READ;
      MEM_WRITE: nxt = mem_ready ? FETCH : tmo ? FAULT : MEM_WRITE;
      EXEC_R:    nxt = R_WB;
      MEM_WB, R_WB, CBZ_EX, B_EX: nxt = FETCH;
      default:   nxt = FAULT;
    endcase
  end
  // State, registered control word, wait counter, fault capture and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= RST;
      ctrl <= '0;
      wcnt <= '0;
      fault <= 1'b0;
      fault_code <= 2'b00;
      instr_count <= '0;
    end else begin
      st <= nxt;
      ctrl <= dec(nxt);
      wcnt <= (nxt == st && st != FAULT) ? wcnt + 1'b1 : '0;
      fault <= nxt == FAULT;
      if (nxt == FAULT && st != FAULT) fault_code <= st == DECODE ? 2'b01 : 2'b10;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end
  assign {PCWriteCond, pcw, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource} = ctrl;
  assign IRWrite = st == FETCH && mem_ready;
  assign PCWrite = pcw || IRWrite;
  assign Reg2Loc = !(st inside {RST, FETCH, FAULT}) && (is_stur || is_cbz);
  assign state = st;
endmodule
